ex_muldiv_unit: RTL and testbench
=================================

Name: ex_muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes EX_D1/EX_D2 and a decoded mult/div op; computes MULT, MULTU, DIV and DIVU over multiple cycles.
- Holds the architectural HI/LO registers and raises MD_Busy so hazard logic stalls IF/ID/ID_EX until the result is written.

Parameters:
- WIDTH, 32, operand/HI/LO width; iteration counter is clog2(WIDTH) bits.
- DIVZ_LO, {WIDTH{1'b1}}, value written to LO on divide-by-zero.

Ports:
- clock  input  1  stage clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- EX_MD_Start  input  1  request a new operation; sampled only in IDLE.
- EX_MD_Op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- EX_D1  input  WIDTH  operand A (multiplicand/dividend).
- EX_D2  input  WIDTH  operand B (multiplier/divisor).
- EX_MTHI  input  1  write EX_D1 to HI.
- EX_MTLO  input  1  write EX_D1 to LO.
- MD_HI  output  WIDTH  HI register (product high / remainder).
- MD_LO  output  WIDTH  LO register (product low / quotient).
- MD_Busy  output  1  operation in progress; stall request.
- MD_Done  output  1  one-cycle pulse when HI/LO are updated by an operation.
- MD_DivByZero  output  1  last completed divide had B==0.

Behaviour:
- Reset (reset==0, asynchronous): state IDLE; MD_HI=0, MD_LO=0, MD_Busy=0, MD_Done=0, MD_DivByZero=0; counter and datapath registers=0.
- MD_Busy is combinational: (state != IDLE).
- States: IDLE -> ITER -> FIX -> IDLE.
- IDLE:
  - If EX_MD_Start at a posedge: latch the op; latch |A| and |B| for signed ops (raw values for unsigned); latch sign_q=A[msb]^B[msb] and sign_r=A[msb] (both 0 for unsigned); clear MD_DivByZero; counter=0; go to ITER.
  - Else, if EX_MTHI/EX_MTLO is set, write HI/LO from EX_D1. Both may be written in the same cycle.
- ITER, multiply:
  - Shift-add, one multiplier bit per cycle, 2*WIDTH-bit unsigned accumulator.
  - Exactly WIDTH cycles, then go to FIX.
- ITER, divide:
  - Restoring divide, one quotient bit per cycle, WIDTH cycles, then go to FIX.
  - If B==0, the datapath result is ignored.
- FIX (one cycle):
  - Signed multiply: negate the 2*WIDTH product if sign_q.
  - Signed divide: negate the quotient if sign_q and the remainder if sign_r.
  - Write HI/LO.
  - Divide by zero: HI=A as originally presented, LO=DIVZ_LO, MD_DivByZero=1.
  - Go to IDLE.
- MD_Done is registered; it is high for exactly the first IDLE cycle after FIX.
- Latency: Start accepted at edge N; MD_Busy high for WIDTH+1 cycles; HI/LO valid and MD_Done=1 in cycle N+WIDTH+2.
- Signed overflow, 0x80000000 / -1: LO=0x80000000, HI=0 (natural result of the abs/negate path).
- While busy: EX_MD_Start, EX_MTHI and EX_MTLO are ignored. Hazard logic guarantees operands are held.
- Start together with MTHI/MTLO in IDLE: Start wins and the MT writes are discarded.
- Reset mid-operation aborts immediately. HI/LO return to 0; there is no partial update.

Optional Feature:
- Macro MD_EARLY_OUT_EN.
- Defined: for multiply, ITER exits to FIX at the end of the cycle in which the remaining (shifted) multiplier becomes zero, or after WIDTH cycles, whichever comes first. A zero multiplier takes 1 ITER cycle. Divide timing is unchanged.
- Undefined: multiply always takes WIDTH ITER cycles. Results are identical in both builds; only timing differs.

Test Plan:
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> after 33 busy cycles HI=0xFFFFFFFE, LO=0x00000001, MD_Done pulses once.
- MULT A=-3 (0xFFFFFFFD), B=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. With MD_EARLY_OUT_EN, MD_Busy is high 4 cycles (3 ITER + FIX); without it, 33 cycles.
- DIV A=-7, B=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU A=7, B=2 -> LO=3, HI=1.
- DIV A=0x12345678, B=0 -> HI=0x12345678, LO=0xFFFFFFFF, MD_DivByZero=1. The next Start clears MD_DivByZero.
- EX_MTHI=1, EX_D1=0xA5A5A5A5 during busy -> HI unchanged. The same write in IDLE sets HI=0xA5A5A5A5 next cycle. Start+MTLO together -> LO holds only the op result.
- Assert reset low at ITER cycle 10 of a DIVU -> immediately MD_Busy=0, HI=LO=0, MD_Done never pulses. A new Start after release completes normally.

Source files
------------

// File: rtl/ex_muldiv_unit_if.sv
// ex_muldiv_unit_if: operand/control inputs and HI/LO/status outputs of the
// EX-stage multiply/divide unit, grouped as one bus.
interface ex_muldiv_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             EX_MD_Start;
    logic [1:0]       EX_MD_Op;
    logic [WIDTH-1:0] EX_D1;
    logic [WIDTH-1:0] EX_D2;
    logic             EX_MTHI;
    logic             EX_MTLO;
    logic [WIDTH-1:0] MD_HI;
    logic [WIDTH-1:0] MD_LO;
    logic             MD_Busy;
    logic             MD_Done;
    logic             MD_DivByZero;

    // Pipeline side: drives operands and op, observes HI/LO and status.
    modport master (
        output EX_MD_Start, EX_MD_Op, EX_D1, EX_D2, EX_MTHI, EX_MTLO,
        input  MD_HI, MD_LO, MD_Busy, MD_Done, MD_DivByZero
    );

    // Unit side.
    modport slave (
        input  EX_MD_Start, EX_MD_Op, EX_D1, EX_D2, EX_MTHI, EX_MTLO,
        output MD_HI, MD_LO, MD_Busy, MD_Done, MD_DivByZero
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative MULT/MULTU/DIV/DIVU with architectural HI/LO.
// Optional macro MD_EARLY_OUT_EN: multiply leaves ITER as soon as the
// remaining multiplier bits are all zero (results unchanged, timing only).
module ex_muldiv_unit #(
    parameter int unsigned      WIDTH   = 32,
    parameter logic [WIDTH-1:0] DIVZ_LO = {WIDTH{1'b1}}
) (
    input  logic            clock,
    input  logic            reset,
    ex_muldiv_unit_if.slave md
);
    localparam int unsigned   CW   = $clog2(WIDTH);
    localparam int unsigned   DW   = 2 * WIDTH;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, ITER, FIX} state_t;

    state_t           state, state_nx;
    logic [1:0]       op_q;          // bit1: divide, bit0: unsigned
    logic             sign_q, sign_r;
    logic [WIDTH-1:0] a_raw, b_abs, mplier;
    logic [DW-1:0]    mcand, acc;    // divide: acc = {remainder, dividend/quotient}
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] hi, lo;
    logic             done, divz;

    logic             signed_in;
    logic [WIDTH-1:0] a_abs_in, b_abs_in;
    logic [WIDTH:0]   div_trial, div_diff;
    logic             div_ge, mul_last, iter_last;
    logic [WIDTH-1:0] div_rem;
    logic [DW-1:0]    prod;
    logic [WIDTH-1:0] fix_hi, fix_lo;

    // Operand magnitudes for the incoming op (signed ops work on |A|, |B|).
    assign signed_in = ~md.EX_MD_Op[0];
    assign a_abs_in  = (signed_in && md.EX_D1[WIDTH-1]) ? -md.EX_D1 : md.EX_D1;
    assign b_abs_in  = (signed_in && md.EX_D2[WIDTH-1]) ? -md.EX_D2 : md.EX_D2;

    // One restoring-divide step: shift in next dividend bit, trial subtract.
    assign div_trial = {acc[DW-1:WIDTH], acc[WIDTH-1]};
    assign div_diff  = div_trial - {1'b0, b_abs};
    assign div_ge    = (div_trial >= {1'b0, b_abs});
    assign div_rem   = div_ge ? div_diff[WIDTH-1:0] : div_trial[WIDTH-1:0];

`ifdef MD_EARLY_OUT_EN
    assign mul_last = (cnt == LAST) || (mplier[WIDTH-1:1] == '0);
`else
    assign mul_last = (cnt == LAST);
`endif
    assign iter_last = op_q[1] ? (cnt == LAST) : mul_last;

    // Sign fix-up and final HI/LO selection, including divide-by-zero.
    always_comb begin
        prod   = sign_q ? -acc : acc;
        fix_hi = prod[DW-1:WIDTH];
        fix_lo = prod[WIDTH-1:0];
        if (op_q[1]) begin
            if (b_abs == '0) begin
                fix_hi = a_raw;
                fix_lo = DIVZ_LO;
            end else begin
                fix_hi = sign_r ? -acc[DW-1:WIDTH] : acc[DW-1:WIDTH];
                fix_lo = sign_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            end
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (md.EX_MD_Start) state_nx = ITER;
            ITER:    if (iter_last) state_nx = FIX;
            FIX:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath, HI/LO and status registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op_q   <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            a_raw  <= '0;
            b_abs  <= '0;
            mplier <= '0;
            mcand  <= '0;
            acc    <= '0;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
            divz   <= 1'b0;
        end else begin
            done <= (state == FIX);
            case (state)
                IDLE: begin
                    if (md.EX_MD_Start) begin
                        op_q   <= md.EX_MD_Op;
                        sign_q <= signed_in & (md.EX_D1[WIDTH-1] ^ md.EX_D2[WIDTH-1]);
                        sign_r <= signed_in & md.EX_D1[WIDTH-1];
                        a_raw  <= md.EX_D1;
                        b_abs  <= b_abs_in;
                        mplier <= b_abs_in;
                        mcand  <= DW'(a_abs_in);
                        acc    <= md.EX_MD_Op[1] ? DW'(a_abs_in) : '0;
                        cnt    <= '0;
                        divz   <= 1'b0;
                    end else begin
                        if (md.EX_MTHI) hi <= md.EX_D1;
                        if (md.EX_MTLO) lo <= md.EX_D1;
                    end
                end
                ITER: begin
                    cnt <= cnt + CW'(1);
                    if (op_q[1]) begin
                        acc <= {div_rem, acc[WIDTH-2:0], div_ge};
                    end else begin
                        if (mplier[0]) acc <= acc + mcand;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                    end
                end
                FIX: begin
                    hi   <= fix_hi;
                    lo   <= fix_lo;
                    divz <= op_q[1] && (b_abs == '0);
                end
                default: ;
            endcase
        end
    end

    assign md.MD_HI        = hi;
    assign md.MD_LO        = lo;
    assign md.MD_Busy      = (state != IDLE);
    assign md.MD_Done      = done;
    assign md.MD_DivByZero = divz;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: directed and random checks of ex_muldiv_unit against a
// cycle-count/arithmetic model of the unit.
module tb_ex_muldiv_unit;
    localparam int unsigned W = 32;
`ifdef MD_EARLY_OUT_EN
    localparam int MULT_NEG_BUSY = 4;
`else
    localparam int MULT_NEG_BUSY = 33;
`endif

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } res_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;
    bit   chk_en = 1'b0;

    ex_muldiv_unit_if #(.WIDTH(W)) md ();
    ex_muldiv_unit #(.WIDTH(W)) dut (.clock(clock), .reset(reset), .md(md));

    always #5 clock = ~clock;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Architectural result of an op computed with 64-bit integer arithmetic.
    function automatic res_t model_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        res_t        r;
        longint      sa, sb;
        logic [63:0] p;
        sa = op[0] ? longint'({32'd0, a}) : longint'({{32{a[31]}}, a});
        sb = op[0] ? longint'({32'd0, b}) : longint'({{32{b[31]}}, b});
        r.dz = 1'b0;
        if (!op[1]) begin
            p = sa * sb;
            r.hi = p[63:32];
            r.lo = p[31:0];
        end else if (b == '0) begin
            r.hi = a;
            r.lo = '1;
            r.dz = 1'b1;
        end else begin
            p = sa / sb;
            r.lo = p[31:0];
            p = sa % sb;
            r.hi = p[31:0];
        end
        return r;
    endfunction

    // Cycles MD_Busy stays high for an op.
    function automatic int model_busy(input logic [1:0] op, input logic [W-1:0] b);
        int iter;
        iter = W;
        if (!op[1]) begin
`ifdef MD_EARLY_OUT_EN
            logic [W-1:0] m;
            m = (!op[0] && b[W-1]) ? -b : b;
            iter = 1;
            for (int i = 0; i < W; i++) if (m[i]) iter = i + 1;
`endif
        end
        return iter + 1;
    endfunction

    // Reference model state.
    int           busy_left;
    logic [W-1:0] m_hi, m_lo;
    logic         m_done, m_dz;
    res_t         pend;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy_left <= 0;
            m_hi      <= '0;
            m_lo      <= '0;
            m_done    <= 1'b0;
            m_dz      <= 1'b0;
            pend      <= '0;
        end else begin
            m_done <= 1'b0;
            if (busy_left > 0) begin
                busy_left <= busy_left - 1;
                if (busy_left == 1) begin
                    m_hi   <= pend.hi;
                    m_lo   <= pend.lo;
                    m_dz   <= pend.dz;
                    m_done <= 1'b1;
                end
            end else if (md.EX_MD_Start) begin
                pend      <= model_op(md.EX_MD_Op, md.EX_D1, md.EX_D2);
                busy_left <= model_busy(md.EX_MD_Op, md.EX_D2);
                m_dz      <= 1'b0;
            end else begin
                if (md.EX_MTHI) m_hi <= md.EX_D1;
                if (md.EX_MTLO) m_lo <= md.EX_D1;
            end
        end
    end

    // Every-cycle comparison against the model, away from the rising edge.
    always @(negedge clock) begin
        if (chk_en) begin
            check("cyc_busy", 64'(md.MD_Busy), 64'(busy_left > 0));
            check("cyc_done", 64'(md.MD_Done), 64'(m_done));
            check("cyc_hi", 64'(md.MD_HI), 64'(m_hi));
            check("cyc_lo", 64'(md.MD_LO), 64'(m_lo));
            check("cyc_dz", 64'(md.MD_DivByZero), 64'(m_dz));
        end
    end

    task automatic wait_done(input string nm, output int busy_cnt);
        int cyc;
        busy_cnt = 0;
        cyc = 0;
        while (!md.MD_Done && cyc < 200) begin
            if (md.MD_Busy) busy_cnt++;
            @(negedge clock);
            cyc++;
        end
        check({nm, "_done"}, 64'(md.MD_Done), 64'd1);
    endtask

    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic mtlo, input logic [W-1:0] eh, input logic [W-1:0] el,
                          input logic edz, input int ebusy, input string nm);
        int bc;
        @(negedge clock);
        md.EX_MD_Start = 1'b1;
        md.EX_MD_Op    = op;
        md.EX_D1       = a;
        md.EX_D2       = b;
        md.EX_MTHI     = 1'b0;
        md.EX_MTLO     = mtlo;
        @(negedge clock);
        md.EX_MD_Start = 1'b0;
        md.EX_MTLO     = 1'b0;
        check({nm, "_dzclr"}, 64'(md.MD_DivByZero), 64'd0);
        wait_done(nm, bc);
        check({nm, "_hi"}, 64'(md.MD_HI), 64'(eh));
        check({nm, "_lo"}, 64'(md.MD_LO), 64'(el));
        check({nm, "_dz"}, 64'(md.MD_DivByZero), 64'(edz));
        check({nm, "_busycyc"}, 64'(bc), 64'(ebusy));
        @(negedge clock);
        check({nm, "_onepulse"}, 64'(md.MD_Done), 64'd0);
    endtask

    function automatic logic [W-1:0] rand_val();
        logic [W-1:0] v;
        case ($urandom % 8)
            0:       v = '0;
            1:       v = 32'h8000_0000;
            2:       v = '1;
            3:       v = W'($urandom % 16);
            4:       v = -W'($urandom % 16);
            default: v = W'($urandom);
        endcase
        return v;
    endfunction

    initial begin
        res_t r;
        int   bc;
        int   npulse;
        md.EX_MD_Start = 1'b0;
        md.EX_MD_Op    = 2'b00;
        md.EX_D1       = '0;
        md.EX_D2       = '0;
        md.EX_MTHI     = 1'b0;
        md.EX_MTLO     = 1'b0;

        // Pin the model with hand-computed values.
        r = model_op(2'b00, 32'hFFFF_FFFD, 32'd5);
        check("pin_mult", 64'({r.hi, r.lo}), 64'hFFFF_FFFF_FFFF_FFF1);
        r = model_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        check("pin_ovf", 64'({r.hi, r.lo}), 64'h0000_0000_8000_0000);
        r = model_op(2'b10, 32'hFFFF_FFF9, 32'd2);
        check("pin_div", 64'({r.hi, r.lo}), 64'hFFFF_FFFF_FFFF_FFFD);

        repeat (3) @(negedge clock);
        check("rst_hi", 64'(md.MD_HI), 64'd0);
        check("rst_lo", 64'(md.MD_LO), 64'd0);
        check("rst_busy", 64'(md.MD_Busy), 64'd0);
        check("rst_done", 64'(md.MD_Done), 64'd0);
        check("rst_dz", 64'(md.MD_DivByZero), 64'd0);
        reset  = 1'b1;
        chk_en = 1'b1;

        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 33, "multu_max");
        run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0, MULT_NEG_BUSY, "mult_neg");
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 33, "div_neg");
        run_op(2'b11, 32'd7, 32'd2, 1'b1, 32'd1, 32'd3, 1'b0, 33, "divu_mtlo");
        run_op(2'b10, 32'h1234_5678, 32'd0, 1'b0, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1, 33, "div_zero");
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000, 1'b0, 33, "div_ovf");

        // MTHI while busy is ignored.
        @(negedge clock);
        md.EX_MD_Start = 1'b1;
        md.EX_MD_Op    = 2'b01;
        md.EX_D1       = 32'd3;
        md.EX_D2       = 32'd4;
        @(negedge clock);
        md.EX_MD_Start = 1'b0;
        md.EX_MTHI     = 1'b1;
        md.EX_D1       = 32'hA5A5_A5A5;
        @(negedge clock);
        md.EX_MTHI     = 1'b0;
        wait_done("mthi_busy", bc);
        check("mthi_busy_hi", 64'(md.MD_HI), 64'd0);
        check("mthi_busy_lo", 64'(md.MD_LO), 64'd12);

        // MTHI in IDLE, then MTHI+MTLO together.
        md.EX_MTHI = 1'b1;
        md.EX_D1   = 32'hA5A5_A5A5;
        @(negedge clock);
        md.EX_MTHI = 1'b0;
        check("mthi_idle_hi", 64'(md.MD_HI), 64'hA5A5_A5A5);
        check("mthi_idle_lo", 64'(md.MD_LO), 64'd12);
        md.EX_MTHI = 1'b1;
        md.EX_MTLO = 1'b1;
        md.EX_D1   = 32'h5A5A_5A5A;
        @(negedge clock);
        md.EX_MTHI = 1'b0;
        md.EX_MTLO = 1'b0;
        check("mtboth_hi", 64'(md.MD_HI), 64'h5A5A_5A5A);
        check("mtboth_lo", 64'(md.MD_LO), 64'h5A5A_5A5A);

        // Reset in the middle of a DIVU aborts with no partial update.
        md.EX_MD_Start = 1'b1;
        md.EX_MD_Op    = 2'b11;
        md.EX_D1       = 32'd100;
        md.EX_D2       = 32'd7;
        @(negedge clock);
        md.EX_MD_Start = 1'b0;
        repeat (10) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("abort_busy", 64'(md.MD_Busy), 64'd0);
        check("abort_hi", 64'(md.MD_HI), 64'd0);
        check("abort_lo", 64'(md.MD_LO), 64'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        npulse = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (md.MD_Done) npulse++;
        end
        check("abort_nodone", 64'(npulse), 64'd0);
        run_op(2'b11, 32'd100, 32'd7, 1'b0, 32'd2, 32'd14, 1'b0, 33, "after_abort");

        // Random traffic: operands only change while idle, control toggles anytime.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clock);
            md.EX_MD_Start = ($urandom % 3) == 0;
            md.EX_MTHI     = ($urandom % 4) == 0;
            md.EX_MTLO     = ($urandom % 4) == 0;
            if (busy_left == 0) begin
                md.EX_MD_Op = 2'($urandom);
                md.EX_D1    = rand_val();
                md.EX_D2    = rand_val();
            end
        end
        md.EX_MD_Start = 1'b0;
        md.EX_MTHI     = 1'b0;
        md.EX_MTLO     = 1'b0;
        repeat (40) @(negedge clock);
        chk_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
